// File: rtl/mp3_cmd_arbiter.sv
// MP3 player command scheduler: round-robin arbitration of bluetooth bytes and push-buttons,
// command execution on SW/VOL, and ACK/NAK reply sequencing. Optional macro: MP3_BTN_NOTIFY_EN.
module mp3_cmd_arbiter #(
  parameter int          NUM_TRACKS = 7,
  parameter int          VOL_MAX    = 15,
  parameter int          VOL_RST    = 8,
  parameter logic [7:0]  NAK_CODE   = 8'hEE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BT_VALID,
  input  logic [7:0] BT_DATA,
  input  logic       BTN_NEXT,
  input  logic       BTN_PREV,
  input  logic       BTN_VUP,
  input  logic       BTN_VDN,
  input  logic       TX_BUSY,
  output logic       TX_START,
  output logic [7:0] TX_DATA,
  output logic [2:0] SW,
  output logic [3:0] VOL,
  output logic       UP,
  output logic       DOWN,
  output logic       BT_DROP
);

  localparam logic [2:0] SW_LAST  = 3'(NUM_TRACKS - 1);
  localparam logic [3:0] VOL_TOP  = 4'(VOL_MAX);
  localparam logic [3:0] VOL_INIT = 4'(VOL_RST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_REPLY = 2'd2
  } state_t;

  function automatic logic cmd_is_valid(input logic [7:0] c);
    logic [7:0] idx;
    logic       v;
    idx = c - 8'h05;
    v   = 1'b0;
    if ((c >= 8'h01) && (c <= 8'h04)) begin
      v = 1'b1;
    end else if ((c >= 8'h05) && (c <= 8'h0B)) begin
      v = (idx < 8'(NUM_TRACKS));
    end else begin
      v = 1'b0;
    end
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic       src_bt_q, src_bt_d;
  logic       last_bt_q, last_bt_d;
  logic       bt_full_q, bt_full_d;
  logic [7:0] bt_byte_q, bt_byte_d;
  logic       btn_full_q, btn_full_d;
  logic [7:0] btn_code_q, btn_code_d;
  logic [3:0] btn_prev_q;
  logic [2:0] sw_q, sw_d;
  logic [3:0] vol_q, vol_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       drop_q, drop_d;
  logic [7:0] tx_data_q, tx_data_d;

  logic [3:0] btn_lvl_s;
  logic [3:0] btn_rise_s;
  logic [7:0] btn_code_s;
  logic       btn_edge_s;
  logic       grant_bt_s;
  logic       grant_btn_s;

  assign btn_lvl_s  = {BTN_NEXT, BTN_PREV, BTN_VUP, BTN_VDN};
  assign btn_rise_s = btn_lvl_s & ~btn_prev_q;
  assign btn_edge_s = |btn_rise_s;

  // Button edge priority encode and round-robin grant.
  always_comb begin
    btn_code_s  = 8'h00;
    grant_bt_s  = 1'b0;
    grant_btn_s = 1'b0;
    if (btn_rise_s[3]) begin
      btn_code_s = 8'h02;
    end else if (btn_rise_s[2]) begin
      btn_code_s = 8'h01;
    end else if (btn_rise_s[1]) begin
      btn_code_s = 8'h03;
    end else if (btn_rise_s[0]) begin
      btn_code_s = 8'h04;
    end else begin
      btn_code_s = 8'h00;
    end
    if (state_q == ST_IDLE) begin
      if (bt_full_q && btn_full_q) begin
        grant_bt_s  = ~last_bt_q;
        grant_btn_s = last_bt_q;
      end else begin
        grant_bt_s  = bt_full_q;
        grant_btn_s = btn_full_q;
      end
    end else begin
      grant_bt_s  = 1'b0;
      grant_btn_s = 1'b0;
    end
  end

  // Next-state: FSM, slot bookkeeping and resource updates.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    src_bt_d   = src_bt_q;
    last_bt_d  = last_bt_q;
    bt_full_d  = bt_full_q;
    bt_byte_d  = bt_byte_q;
    btn_full_d = btn_full_q;
    btn_code_d = btn_code_q;
    sw_d       = sw_q;
    vol_d      = vol_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    drop_d     = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_bt_s) begin
          cmd_d     = bt_byte_q;
          src_bt_d  = 1'b1;
          last_bt_d = 1'b1;
          state_d   = ST_EXEC;
        end else if (grant_btn_s) begin
          cmd_d     = btn_code_q;
          src_bt_d  = 1'b0;
          last_bt_d = 1'b0;
          state_d   = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (cmd_q)
          8'h01: sw_d = (sw_q == 3'd0) ? SW_LAST : (sw_q - 3'd1);
          8'h02: sw_d = (sw_q == SW_LAST) ? 3'd0 : (sw_q + 3'd1);
          8'h03: begin
            if (vol_q < VOL_TOP) begin
              vol_d = vol_q + 4'd1;
              up_d  = 1'b1;
            end else begin
              vol_d = vol_q;
            end
          end
          8'h04: begin
            if (vol_q > 4'd0) begin
              vol_d  = vol_q - 4'd1;
              down_d = 1'b1;
            end else begin
              vol_d = vol_q;
            end
          end
          8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B: begin
            // Low three bits minus 5 (mod 8) maps 05..0B onto 0..6.
            if (cmd_is_valid(cmd_q)) begin
              sw_d = cmd_q[2:0] - 3'd5;
            end else begin
              sw_d = sw_q;
            end
          end
          default: sw_d = sw_q;
        endcase
        if (src_bt_q) begin
          tx_data_d = cmd_is_valid(cmd_q) ? cmd_q : NAK_CODE;
          state_d   = ST_REPLY;
        end else begin
`ifdef MP3_BTN_NOTIFY_EN
          tx_data_d = cmd_q;
          state_d   = ST_REPLY;
`else
          state_d   = ST_IDLE;
`endif
        end
      end
      ST_REPLY: begin
        if (!TX_BUSY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte may refill the BT slot in the same cycle it is granted.
    if (BT_VALID && (!bt_full_q || grant_bt_s)) begin
      bt_full_d = 1'b1;
      bt_byte_d = BT_DATA;
    end else if (grant_bt_s) begin
      bt_full_d = 1'b0;
    end else begin
      bt_full_d = bt_full_q;
    end
    drop_d = BT_VALID && bt_full_q && !grant_bt_s;

    if (grant_btn_s) begin
      btn_full_d = 1'b0;
    end else if (btn_edge_s && !btn_full_q) begin
      btn_full_d = 1'b1;
      btn_code_d = btn_code_s;
    end else begin
      btn_full_d = btn_full_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      src_bt_q   <= 1'b0;
      last_bt_q  <= 1'b0;
      bt_full_q  <= 1'b0;
      bt_byte_q  <= 8'h00;
      btn_full_q <= 1'b0;
      btn_code_q <= 8'h00;
      btn_prev_q <= 4'b0000;
      sw_q       <= 3'd0;
      vol_q      <= VOL_INIT;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      drop_q     <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      src_bt_q   <= src_bt_d;
      last_bt_q  <= last_bt_d;
      bt_full_q  <= bt_full_d;
      bt_byte_q  <= bt_byte_d;
      btn_full_q <= btn_full_d;
      btn_code_q <= btn_code_d;
      btn_prev_q <= btn_lvl_s;
      sw_q       <= sw_d;
      vol_q      <= vol_d;
      up_q       <= up_d;
      down_q     <= down_d;
      drop_q     <= drop_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Start is gated by the live busy level so it can never overlap TX_BUSY.
  assign TX_START = (state_q == ST_REPLY) && !TX_BUSY;
  assign TX_DATA  = tx_data_q;
  assign SW       = sw_q;
  assign VOL      = vol_q;
  assign UP       = up_q;
  assign DOWN     = down_q;
  assign BT_DROP  = drop_q;

endmodule

// File: tb/tb_mp3_cmd_arbiter.sv
// Directed bench for mp3_cmd_arbiter: table of BT commands plus hand-written corner sequences.
module tb_mp3_cmd_arbiter;

`ifdef MP3_BTN_NOTIFY_EN
  localparam int BTN_TX = 1;
`else
  localparam int BTN_TX = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       BT_VALID;
  logic [7:0] BT_DATA;
  logic       BTN_NEXT, BTN_PREV, BTN_VUP, BTN_VDN;
  logic       TX_BUSY;
  logic       TX_START;
  logic [7:0] TX_DATA;
  logic [2:0] SW;
  logic [3:0] VOL;
  logic       UP, DOWN, BT_DROP;

  always #5 CLK = ~CLK;

  mp3_cmd_arbiter dut (
    .CLK(CLK), .RST(RST), .BT_VALID(BT_VALID), .BT_DATA(BT_DATA),
    .BTN_NEXT(BTN_NEXT), .BTN_PREV(BTN_PREV), .BTN_VUP(BTN_VUP), .BTN_VDN(BTN_VDN),
    .TX_BUSY(TX_BUSY), .TX_START(TX_START), .TX_DATA(TX_DATA),
    .SW(SW), .VOL(VOL), .UP(UP), .DOWN(DOWN), .BT_DROP(BT_DROP)
  );

  typedef struct {
    logic [7:0] b;
    int         sw;
    int         vol;
    int         tx;
    int         up;
    int         dn;
  } vec_t;

  vec_t tbl[64];
  int   n_vec;
  int   checks   = 0;
  int   failures = 0;

  int         idx, tx_cnt, up_cnt, dn_cnt, drop_cnt, tx_first_idx, drop_idx, viol;
  logic [7:0] tx_first, tx_last;
  int         sw_at[64];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    idx = 0; tx_cnt = 0; up_cnt = 0; dn_cnt = 0; drop_cnt = 0; viol = 0;
    tx_first_idx = -1; drop_idx = -1; tx_first = 8'h00; tx_last = 8'h00;
    for (int k = 0; k < 64; k++) sw_at[k] = -1;
  endtask

  // Inputs for the current cycle are already set; sample #1 later, then advance.
  task automatic cyc();
    #1;
    if (TX_START) begin
      if (tx_cnt == 0) begin
        tx_first     = TX_DATA;
        tx_first_idx = idx;
      end
      tx_last = TX_DATA;
      tx_cnt++;
      if (TX_BUSY) viol++;
    end
    if (UP) up_cnt++;
    if (DOWN) dn_cnt++;
    if (UP && DOWN) viol++;
    if (BT_DROP) begin
      drop_cnt++;
      drop_idx = idx;
    end
    if (idx < 64) sw_at[idx] = int'(SW);
    idx++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0; BT_VALID = 1'b0; BT_DATA = 8'h00; TX_BUSY = 1'b0;
    BTN_NEXT = 1'b0; BTN_PREV = 1'b0; BTN_VUP = 1'b0; BTN_VDN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    clr_mon();
  endtask

  task automatic add(input logic [7:0] b, input int sw, input int vol, input int tx,
                     input int up, input int dn);
    tbl[n_vec] = '{b, sw, vol, tx, up, dn};
    n_vec++;
  endtask

  initial begin
    RST = 1'b0; BT_VALID = 1'b0; BT_DATA = 8'h00; TX_BUSY = 1'b0;
    BTN_NEXT = 1'b0; BTN_PREV = 1'b0; BTN_VUP = 1'b0; BTN_VDN = 1'b0;
    n_vec = 0;

    add(8'h02, 1, 8, 8'h02, 0, 0);
    add(8'h02, 2, 8, 8'h02, 0, 0);
    add(8'h02, 3, 8, 8'h02, 0, 0);
    add(8'h02, 4, 8, 8'h02, 0, 0);
    add(8'h05, 0, 8, 8'h05, 0, 0);
    add(8'h01, 6, 8, 8'h01, 0, 0);
    add(8'h0B, 6, 8, 8'h0B, 0, 0);
    add(8'h0C, 6, 8, 8'hEE, 0, 0);
    add(8'h0A, 5, 8, 8'h0A, 0, 0);
    add(8'h02, 6, 8, 8'h02, 0, 0);
    add(8'h02, 0, 8, 8'h02, 0, 0);
    for (int k = 9; k <= 15; k++) add(8'h03, 0, k, 8'h03, 1, 0);
    add(8'h03, 0, 15, 8'h03, 0, 0);
    for (int k = 14; k >= 0; k--) add(8'h04, 0, k, 8'h04, 0, 1);
    add(8'h04, 0, 0, 8'h04, 0, 0);
    add(8'h00, 0, 0, 8'hEE, 0, 0);
    add(8'hFF, 0, 0, 8'hEE, 0, 0);

    // Reset values
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_sw", int'(SW), 0);
    chk("rst_vol", int'(VOL), 8);
    chk("rst_tx_start", int'(TX_START), 0);
    chk("rst_tx_data", int'(TX_DATA), 0);
    chk("rst_up_down_drop", int'({UP, DOWN, BT_DROP}), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Table of BT commands, each strobe followed by 10 observed cycles
    for (int i = 0; i < n_vec; i++) begin
      clr_mon();
      BT_VALID = 1'b1;
      BT_DATA  = tbl[i].b;
      cyc();
      BT_VALID = 1'b0;
      repeat (9) cyc();
      chk($sformatf("tbl%0d_sw", i), int'(SW), tbl[i].sw);
      chk($sformatf("tbl%0d_vol", i), int'(VOL), tbl[i].vol);
      chk($sformatf("tbl%0d_tx_cnt", i), tx_cnt, 1);
      chk($sformatf("tbl%0d_tx_data", i), int'(tx_first), tbl[i].tx);
      chk($sformatf("tbl%0d_tx_cycle", i), tx_first_idx, 3);
      chk($sformatf("tbl%0d_up", i), up_cnt, tbl[i].up);
      chk($sformatf("tbl%0d_dn", i), dn_cnt, tbl[i].dn);
      chk($sformatf("tbl%0d_viol", i), viol, 0);
      if (i == 0) begin
        chk("lat_sw_cycle2", sw_at[2], 0);
        chk("lat_sw_cycle3", sw_at[3], 1);
      end
    end

    // BT byte and button edge in the same cycle: BT first, then button
    do_reset();
    BT_VALID = 1'b1; BT_DATA = 8'h02; BTN_PREV = 1'b1;
    cyc();
    BT_VALID = 1'b0;
    repeat (11) cyc();
    chk("mix_sw_after_bt", sw_at[3], 1);
    chk("mix_sw_before_btn", sw_at[5], 1);
    chk("mix_sw_after_btn", sw_at[6], 0);
    chk("mix_sw_final", int'(SW), 0);
    chk("mix_tx_cnt", tx_cnt, 1 + BTN_TX);
    chk("mix_tx_first", int'(tx_first), 8'h02);
    BTN_PREV = 1'b0;

    // Simultaneous NEXT and VDN edges: NEXT wins, VDN discarded
    do_reset();
    BTN_NEXT = 1'b1; BTN_VDN = 1'b1;
    repeat (10) cyc();
    chk("prio_sw", int'(SW), 1);
    chk("prio_vol", int'(VOL), 8);
    chk("prio_dn", dn_cnt, 0);
    chk("prio_tx_cnt", tx_cnt, BTN_TX);
    BTN_NEXT = 1'b0; BTN_VDN = 1'b0;
    repeat (2) cyc();

    // Edge arriving while the button slot is full is discarded
    clr_mon();
    BTN_PREV = 1'b1;
    cyc();
    BTN_VUP = 1'b1;
    repeat (9) cyc();
    chk("full_sw", int'(SW), 0);
    chk("full_vol", int'(VOL), 8);
    chk("full_up", up_cnt, 0);
    BTN_PREV = 1'b0; BTN_VUP = 1'b0;

    // TX_BUSY held: reply waits, a second queued byte is dropped
    do_reset();
    TX_BUSY = 1'b1;
    BT_VALID = 1'b1; BT_DATA = 8'h05;
    cyc();
    BT_VALID = 1'b0;
    repeat (3) cyc();
    BT_VALID = 1'b1; BT_DATA = 8'h03;
    cyc();
    cyc();
    BT_VALID = 1'b0;
    repeat (5) cyc();
    chk("busy_tx_cnt_held", tx_cnt, 0);
    chk("busy_drop_cnt", drop_cnt, 1);
    chk("busy_drop_cycle", drop_idx, 6);
    TX_BUSY = 1'b0;
    repeat (10) cyc();
    chk("busy_tx_cnt", tx_cnt, 2);
    chk("busy_tx_first", int'(tx_first), 8'h05);
    chk("busy_tx_first_cycle", tx_first_idx, 11);
    chk("busy_tx_last", int'(tx_last), 8'h03);
    chk("busy_vol", int'(VOL), 9);
    chk("busy_up", up_cnt, 1);
    chk("busy_viol", viol, 0);

    // Reset while waiting in REPLY
    do_reset();
    TX_BUSY = 1'b1;
    BT_VALID = 1'b1; BT_DATA = 8'h02;
    cyc();
    BT_VALID = 1'b0;
    repeat (5) cyc();
    chk("rr_sw_before", int'(SW), 1);
    chk("rr_tx_data_before", int'(TX_DATA), 8'h02);
    RST = 1'b0;
    TX_BUSY = 1'b0;
    #1;
    chk("rr_sw", int'(SW), 0);
    chk("rr_vol", int'(VOL), 8);
    chk("rr_tx_start", int'(TX_START), 0);
    chk("rr_tx_data", int'(TX_DATA), 0);
    @(negedge CLK);
    RST = 1'b1;
    clr_mon();
    repeat (10) cyc();
    chk("rr_tx_after", tx_cnt, 0);
    chk("rr_sw_after", int'(SW), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp3_cmd_arbiter.md
Name: mp3_cmd_arbiter

Overview:
- Command scheduler for the MP3 player control resources: track select (SW) and volume (VOL, UP/DOWN pulses).
- Two requesters share these resources: the bluetooth UART receive byte stream and the on-board push-buttons. The block arbitrates between them round-robin, decodes and executes one command at a time, and sequences an ACK/NAK reply byte into the UART transmitter through a start/busy handshake.
- Sits between the UART receiver/transmitter and the player core.

Parameters:
- NUM_TRACKS, 7, number of selectable tracks; SW ranges 0..NUM_TRACKS-1 (must be ≤8).
- VOL_MAX, 15, maximum volume level; VOL ranges 0..VOL_MAX.
- VOL_RST, 8, VOL value at reset.
- NAK_CODE, 8'hEE, reply byte sent for an unrecognised bluetooth byte.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- BT_VALID  in  1  one-cycle strobe: BT_DATA holds a received byte.
- BT_DATA  in  8  received command byte.
- BTN_NEXT, BTN_PREV, BTN_VUP, BTN_VDN  in  1 each  debounced, synchronous button levels; rising edge = request.
- TX_BUSY  in  1  transmitter busy.
- TX_START  out  1  one-cycle transmit request.
- TX_DATA  out  8  reply byte, valid while TX_START=1.
- SW  out  3  current track index.
- VOL  out  4  current volume level.
- UP  out  1  one-cycle pulse when VOL increments.
- DOWN  out  1  one-cycle pulse when VOL decrements.
- BT_DROP  out  1  one-cycle pulse when a BT byte is discarded.

Behaviour:
- Reset (RST=0, async): SW=0, VOL=VOL_RST, TX_START=0, TX_DATA=0, UP=DOWN=BT_DROP=0. Pending slots are emptied, the RR pointer is set to favour BT, FSM goes to IDLE, and button edge history is cleared. Reset mid-command discards the command and any reply.
- Command codes:
  - 01 prev: SW-1, wraps 0→NUM_TRACKS-1.
  - 02 next: SW+1, wraps NUM_TRACKS-1→0.
  - 03 vol up: saturates at VOL_MAX.
  - 04 vol down: saturates at 0.
  - 05..0B: direct select SW=code-5. Codes whose index is ≥NUM_TRACKS are invalid.
  - All other bytes are invalid: no resource change.
- BT slot, one byte deep:
  - BT_VALID with the slot empty, or with the slot being granted in the same cycle, loads the slot.
  - BT_VALID with the slot full and not being granted: byte discarded, BT_DROP=1 next cycle.
- Button slot, one entry deep:
  - Rising edges are detected against registered previous levels.
  - Several edges in the same cycle: priority NEXT>PREV>VUP>VDN; the losers are discarded.
  - An edge arriving while the slot is full is silently discarded.
- Arbitration (in IDLE, both slots full): grant the source not granted last, then toggle the pointer. With a single pending slot, grant it.
- FSM states:
  - IDLE: no pending slot → stay. Otherwise latch the granted command and its source, free that slot, go to EXEC.
  - EXEC (1 cycle): update SW/VOL. UP/DOWN pulse only if VOL actually changes. Source BT → REPLY; source button → IDLE.
  - REPLY: wait while TX_BUSY=1. When TX_BUSY=0, drive TX_START=1 for one cycle with TX_DATA = command byte if valid, NAK_CODE if invalid, then go to IDLE. TX_DATA holds its value afterwards.
- Latency (idle block, TX_BUSY=0):
  - BT_VALID in cycle 0 → slot loaded, cycle 1 IDLE grant, cycle 2 EXEC.
  - SW/VOL/UP/DOWN change at the end of cycle 2 (visible in cycle 3).
  - TX_START=1 in cycle 3.
- Sustained throughput: one BT command per 3 cycles plus TX_BUSY wait time.
- UP and DOWN are never both asserted. TX_START is never asserted while TX_BUSY=1.

Optional Feature:
- Macro MP3_BTN_NOTIFY_EN.
- Defined: button commands also go EXEC→REPLY and transmit the equivalent code (01/02/03/04) so the phone sees local changes.
- Undefined: button commands send no reply and TX_START is driven only for BT commands.

Test Plan:
- Reset, then BT_VALID with 8'h02 four times, spaced 10 cycles, TX_BUSY=0 → SW 1,2,3,4; four TX_START pulses with TX_DATA=02; first SW change visible 3 cycles after the strobe.
- SW=0, BT byte 01 → SW=6; BT 0B → SW=6; BT 0C → SW unchanged, TX_DATA=EE.
- VOL=VOL_MAX, BT 03 → VOL stays 15, UP stays 0, TX_DATA=03; then BT 04 → VOL=14, DOWN pulses exactly one cycle.
- Hold TX_BUSY=1 after BT 05, then send two more BT bytes → second extra byte gives BT_DROP=1, TX_START stays low until TX_BUSY falls, then one TX_START with TX_DATA=05.
- BT 02 and a BTN_PREV edge in the same cycle, from reset → BT executes first, then button; SW ends at 0; only one TX_START (macro undefined).
- Assert RST low while in REPLY with TX_BUSY=1 → all outputs return to reset values immediately; no TX_START after release.
